sync_frame_tx: RTL and testbench
================================

Name: sync_frame_tx

Overview:
- Serial frame transmitter that produces the bit stream consumed by the FSM-family "0110" Mealy sequence detectors.
- Accepts a parallel word over a valid/ready handshake and emits the sync marker 0110, then the payload MSB-first.
- Inserts stuff bits so that 0110 appears on the line only as the final bit of a real marker.
- Sits between a byte source and the serial line, paced by a bit-enable strobe.

Parameters:
- DATA_W, 8, payload width in bits (>=2).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- bit_en  input  1  bit-time strobe; at most one line bit is emitted per cycle with bit_en=1.
- in_data  input  DATA_W  payload word.
- in_valid  input  1  source has a word.
- in_ready  output  1  block can accept a word; combinational, equals (state==IDLE).
- tx_bit  output  1  registered serial line bit.
- tx_frame  output  1  registered; high while tx_bit carries a marker, payload, stuff or parity bit.
- tx_stuff  output  1  registered; high while tx_bit carries a stuff bit.

Behaviour:
- Reset values: tx_bit=1, tx_frame=0, tx_stuff=0, state=IDLE, in_ready=1, hist=3'b111.
- hist is the last three emitted line bits, oldest first. It shifts on every bit_en cycle in every state, including IDLE.
- Handshake:
  - Accept occurs when in_valid && in_ready, independent of bit_en.
  - in_data is latched into the shift register and the state goes to SYNC with index=0.
  - in_ready drops the following cycle.
- States:
  - IDLE, SYNC (index 0..3), DATA (index DATA_W-1..0), and PAR only with the optional feature.
- Line update occurs only on bit_en cycles; tx_bit, tx_frame and tx_stuff hold between bit_en cycles.
- IDLE on bit_en:
  - tx_bit=1, tx_frame=0.
  - An accept cycle that is also a bit_en cycle emits this idle 1 first; the marker starts on a later bit_en.
- Stuff rule, applied in SYNC, DATA and PAR on bit_en:
  - Condition: hist==3'b011, except when emitting SYNC index 3.
  - Action: emit tx_bit=1 with tx_stuff=1, tx_frame=1, and do not advance index.
  - At most one stuff bit precedes any real bit; after a stuff, hist becomes 111.
- SYNC bits, index 0..3, are 0,1,1,0. SYNC index 3 is never stuffed, because it is the intended detection point.
- DATA emits the MSB first. After the LSB, the state goes to IDLE (or PAR), and in_ready rises the next cycle.
- Resulting guarantee: a detector for 0110 fires only on marker bit 3.
- Latency:
  - The first marker bit appears on tx_bit at the first bit_en cycle strictly after the accept cycle.
  - A frame occupies 4+DATA_W+stuffs bit times.
- bit_en held low pauses transmission indefinitely with no state change.
- Mid-frame rst aborts the frame. The next cycle shows reset values; the word is dropped and not retransmitted.
- in_valid while busy is ignored; in_data changes while busy have no effect.

Optional Feature:
- Macro: SYNC_TX_PARITY_EN.
- When defined:
  - After the LSB, state PAR emits one even-parity bit (XOR of the DATA_W payload bits).
  - The parity bit is subject to the stuff rule, then the state goes to IDLE.
- When undefined:
  - No PAR state; DATA goes directly to IDLE.
  - Frame length is 4+DATA_W+stuffs.

Test Plan:
- Reset, bit_en=1 constantly -> tx_bit=1, tx_frame=0, tx_stuff=0, in_ready=1 every cycle.
- Send 0xA5, bit_en=1 constantly -> line bits 0110 10100101, 12 bits with tx_frame=1, tx_stuff never set; in_ready=1 the cycle after the last bit.
- Send 0x66 -> 0110 0 1 1 S 0 0 1 1 S 0 (S = stuffed 1, tx_stuff=1), 14 frame bits, detector pulses exactly once.
- Send 0xFF -> 0110 1 1 S 1 1 1 1 1 1, 13 frame bits; with bit_en toggling every other cycle the same sequence appears at half rate.
- Back-to-back words:
  - Stimulus: in_valid held high with 0x01 then 0x00, bit_en=1.
  - Response after 0x01: idle 1, then a stuff bit before the marker's first 0 (hist was 011).
  - Response on the line: the detector fires only at the two marker ends.
- Assert rst during DATA bit 3 of 0x5A -> next cycle tx_bit=1, tx_frame=0, in_ready=1; a following 0x5A frame is emitted complete and correct.
- With SYNC_TX_PARITY_EN defined: send 0x07 -> 0110 0 0 0 0 0 1 1 S 1 then parity 1, detector fires once.

Source files
------------

// File: rtl/sync_frame_tx_if.sv
// sync_frame_tx_if
// Bundles the byte-source handshake and the serial line of sync_frame_tx.
//   bit_en    : bit-time strobe driven by the line pacing logic
//   in_data   : payload word, DATA_W bits
//   in_valid  : source has a word
//   in_ready  : transmitter can accept a word
//   tx_bit    : serial line bit
//   tx_frame  : line bit belongs to a frame (marker, payload, stuff or parity)
//   tx_stuff  : line bit is a stuff bit
// Modports: master = source/line side, slave = the transmitter.
interface sync_frame_tx_if #(
  parameter int DATA_W = 8
) ();

  logic              bit_en;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              tx_bit;
  logic              tx_frame;
  logic              tx_stuff;

  modport master (
    output bit_en,
    output in_data,
    output in_valid,
    input  in_ready,
    input  tx_bit,
    input  tx_frame,
    input  tx_stuff
  );

  modport slave (
    input  bit_en,
    input  in_data,
    input  in_valid,
    output in_ready,
    output tx_bit,
    output tx_frame,
    output tx_stuff
  );

endinterface

// File: rtl/sync_frame_tx.sv
// sync_frame_tx
// Serial frame transmitter feeding the "0110" sequence detectors. A word taken
// over a valid/ready handshake is sent as the sync marker 0110 followed by the
// payload MSB-first. A stuff 1 is inserted whenever the last three line bits
// are 011, so the pattern 0110 can only complete on the final marker bit.
// Optional feature macro: SYNC_TX_PARITY_EN adds one even-parity bit after
// the payload (itself subject to stuffing).
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : sync_frame_tx_if.slave (bit_en, in_data, in_valid, in_ready,
//          tx_bit, tx_frame, tx_stuff)
module sync_frame_tx #(
  parameter int DATA_W = 8
) (
  input logic           clk,
  input logic           rst,
  sync_frame_tx_if.slave bus
);

  // Index must hold both the marker position (0..3) and the payload bit
  // position (DATA_W-1..0).
  localparam int IW = ($clog2(DATA_W) > 2) ? $clog2(DATA_W) : 2;

  localparam logic [3:0] SYNC_PAT = 4'b0110;

`ifdef SYNC_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [2:0]        hist_q, hist_d;
  logic              tx_bit_q, tx_bit_d;
  logic              tx_frame_q, tx_frame_d;
  logic              tx_stuff_q, tx_stuff_d;
`ifdef SYNC_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic              accept;
  logic              real_bit;
  logic              stuff_needed;
  logic [1:0]        sync_sel;

  assign bus.in_ready = (state_q == IDLE);
  assign bus.tx_bit   = tx_bit_q;
  assign bus.tx_frame = tx_frame_q;
  assign bus.tx_stuff = tx_stuff_q;

  assign accept   = bus.in_valid && (state_q == IDLE);
  assign sync_sel = 2'd3 - idx_q[1:0];

  // The bit the current state would put on the line if no stuff were needed.
  always_comb begin
    real_bit = 1'b1;
    case (state_q)
      SYNC:    real_bit = SYNC_PAT[sync_sel];
      DATA:    real_bit = shreg_q[DATA_W-1];
`ifdef SYNC_TX_PARITY_EN
      PAR:     real_bit = par_q;
`endif
      default: real_bit = 1'b1;
    endcase
  end

  // Marker bit 3 is the intended detection point, so it is never stuffed even
  // though hist is always 011 in front of it.
  assign stuff_needed = (hist_q == 3'b011) && !((state_q == SYNC) && (idx_q == IW'(3)));

  // Next-state and line logic. Everything holds unless bit_en is high, apart
  // from the handshake, which is accepted on any cycle while idle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    hist_d     = hist_q;
    tx_bit_d   = tx_bit_q;
    tx_frame_d = tx_frame_q;
    tx_stuff_d = tx_stuff_q;
`ifdef SYNC_TX_PARITY_EN
    par_d      = par_q;
`endif

    if (bus.bit_en) begin
      if (state_q == IDLE) begin
        tx_bit_d   = 1'b1;
        tx_frame_d = 1'b0;
        tx_stuff_d = 1'b0;
        hist_d     = {hist_q[1:0], 1'b1};
      end else if (stuff_needed) begin
        // Stuff a 1 and retry the same real bit on the next bit time.
        tx_bit_d   = 1'b1;
        tx_frame_d = 1'b1;
        tx_stuff_d = 1'b1;
        hist_d     = {hist_q[1:0], 1'b1};
      end else begin
        tx_bit_d   = real_bit;
        tx_frame_d = 1'b1;
        tx_stuff_d = 1'b0;
        hist_d     = {hist_q[1:0], real_bit};
        case (state_q)
          SYNC: begin
            if (idx_q == IW'(3)) begin
              state_d = DATA;
              idx_d   = IW'(DATA_W - 1);
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
          DATA: begin
            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            if (idx_q == '0) begin
`ifdef SYNC_TX_PARITY_EN
              state_d = PAR;
`else
              state_d = IDLE;
`endif
            end else begin
              idx_d = idx_q - IW'(1);
            end
          end
`ifdef SYNC_TX_PARITY_EN
          PAR: state_d = IDLE;
`endif
          default: state_d = IDLE;
        endcase
      end
    end

    // An accept on a bit_en cycle still lets the idle 1 above go out first;
    // the marker starts on the next bit_en.
    if (accept) begin
      state_d = SYNC;
      idx_d   = '0;
      shreg_d = bus.in_data;
`ifdef SYNC_TX_PARITY_EN
      par_d   = ^bus.in_data;
`endif
    end
  end

  // State and line registers; reset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      shreg_q    <= '0;
      hist_q     <= 3'b111;
      tx_bit_q   <= 1'b1;
      tx_frame_q <= 1'b0;
      tx_stuff_q <= 1'b0;
`ifdef SYNC_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      hist_q     <= hist_d;
      tx_bit_q   <= tx_bit_d;
      tx_frame_q <= tx_frame_d;
      tx_stuff_q <= tx_stuff_d;
`ifdef SYNC_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_sync_frame_tx.sv
// tb_sync_frame_tx
// Directed bench for sync_frame_tx: drives words through the interface,
// compares each line bit, stuff flag and a reference 0110 detector against
// hand-computed frames (MSB-first vectors, first line bit in the top bit).
module tb_sync_frame_tx;

  logic clk = 1'b0;
  logic rst;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  sync_frame_tx_if #(.DATA_W(8)) bus ();

  sync_frame_tx #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int idx,
                             input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.bit_en = 1'b1;
      tick();
    end
  endtask

  // Offers w0 (then w1 when nwords==2, keeping in_valid high) and checks the
  // next nbits frame bits against eb/es/ef (bit, stuff, detector fire).
  // With abort set, rst is pulsed once nbits frame bits have appeared.
  task automatic applyStimulus(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                               input int nwords, input int nbits,
                               input logic [31:0] eb, input logic [31:0] es,
                               input logic [31:0] ef, input bit half, input bit abort);
    logic [3:0] hist4;
    logic       fire;
    logic       en;
    logic       rdy;
    logic       last_bit;
    int         k;
    int         cyc;
    int         accepts;
    hist4    = 4'b1111;
    k        = 0;
    cyc      = 0;
    accepts  = 0;
    last_bit = bus.tx_bit;
    bus.in_data  = w0;
    bus.in_valid = 1'b1;
    while (k < nbits && cyc < 400) begin
      en = half ? (cyc % 2 == 0) : 1'b1;
      bus.bit_en = en;
      rdy = bus.in_ready;
      tick();
      if (rdy && bus.in_valid) begin
        accepts++;
        if (accepts < nwords) bus.in_data = w1;
        else bus.in_valid = 1'b0;
      end
      if (en) begin
        hist4 = {hist4[2:0], bus.tx_bit};
        fire  = (hist4 == 4'b0110);
        if (bus.tx_frame) begin
          checkOutput({tag, "_bit"},   k, bus.tx_bit,   eb[nbits-1-k]);
          checkOutput({tag, "_stuff"}, k, bus.tx_stuff, es[nbits-1-k]);
          checkOutput({tag, "_fire"},  k, fire,         ef[nbits-1-k]);
          k++;
        end else begin
          checkOutput({tag, "_idlefire"}, k, fire, 1'b0);
        end
        last_bit = bus.tx_bit;
      end else begin
        checkOutput({tag, "_hold"}, cyc, bus.tx_bit, last_bit);
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.bit_en   = 1'b1;
    checkOutput({tag, "_len"}, 0, k, nbits);
    if (abort) begin
      rst = 1'b1;
      tick();
      checkOutput({tag, "_rst_bit"},   0, bus.tx_bit,   1'b1);
      checkOutput({tag, "_rst_frame"}, 0, bus.tx_frame, 1'b0);
      checkOutput({tag, "_rst_stuff"}, 0, bus.tx_stuff, 1'b0);
      checkOutput({tag, "_rst_ready"}, 0, bus.in_ready, 1'b1);
      rst = 1'b0;
    end else begin
      checkOutput({tag, "_ready_after"}, 0, bus.in_ready, 1'b1);
      tick();
      checkOutput({tag, "_tail_frame"}, 0, bus.tx_frame, 1'b0);
      checkOutput({tag, "_tail_bit"},   0, bus.tx_bit,   1'b1);
      checkOutput({tag, "_tail_stuff"}, 0, bus.tx_stuff, 1'b0);
    end
    idle(4);
  endtask

  initial begin
    rst          = 1'b1;
    bus.bit_en   = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    tick();
    tick();
    checkOutput("rst_bit",   0, bus.tx_bit,   1'b1);
    checkOutput("rst_frame", 0, bus.tx_frame, 1'b0);
    checkOutput("rst_stuff", 0, bus.tx_stuff, 1'b0);
    checkOutput("rst_ready", 0, bus.in_ready, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("idle_bit",   i, bus.tx_bit,   1'b1);
      checkOutput("idle_frame", i, bus.tx_frame, 1'b0);
      checkOutput("idle_stuff", i, bus.tx_stuff, 1'b0);
      checkOutput("idle_ready", i, bus.in_ready, 1'b1);
    end

`ifdef SYNC_TX_PARITY_EN
    // 0110 00000 1 1 S 1 P(=1)
    applyStimulus("p07", 8'h07, 8'h00, 1, 14,
                  32'b01100000011111, 32'b00000000000100, 32'b00010000000000, 1'b0, 1'b0);
`else
    // 0110 10100101
    applyStimulus("a5", 8'hA5, 8'h00, 1, 12,
                  32'b011010100101, 32'b000000000000, 32'b000100000000, 1'b0, 1'b0);
    // 0110 0 1 1 S 0 0 1 1 S 0
    applyStimulus("x66", 8'h66, 8'h00, 1, 14,
                  32'b01100111001110, 32'b00000001000010, 32'b00010000000000, 1'b0, 1'b0);
    // 0110 1 1 S 1 1 1 1 1 1, full rate then half rate
    applyStimulus("ff", 8'hFF, 8'h00, 1, 13,
                  32'b0110111111111, 32'b0000001000000, 32'b0001000000000, 1'b0, 1'b0);
    applyStimulus("ff_half", 8'hFF, 8'h00, 1, 13,
                  32'b0110111111111, 32'b0000001000000, 32'b0001000000000, 1'b1, 1'b0);
    // 0110 00000001 | idle 1 | S 0110 00000000
    applyStimulus("b2b", 8'h01, 8'h00, 2, 25,
                  32'b0110000000011011000000000, 32'b0000000000001000000000000,
                  32'b0001000000000000100000000, 1'b0, 1'b0);
    // 0x5A aborted just before DATA bit 3, then resent whole:
    // 0110 0 1 0 1 1 S 0 1 0
    applyStimulus("x5a_abort", 8'h5A, 8'h00, 1, 8,
                  32'b01100101, 32'b00000000, 32'b00010000, 1'b0, 1'b1);
    applyStimulus("x5a", 8'h5A, 8'h00, 1, 13,
                  32'b0110010111010, 32'b0000000001000, 32'b0001000000000, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
